// File: rtl/wbuserialize.sv
// Pops CW-bit codewords and emits them MSB-first as printable chars, closing each burst with '\n'.
// First char one cycle after the pop; the byte stays held while i_tx_busy; keep-alive word after 2^LGIDLE quiet cycles.
module wbuserialize #(
  parameter int             CW        = 36,
  parameter int             LGIDLE    = 22,
  parameter logic [CW-1:0]  IDLE_WORD = '0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_fifo_valid,
  input  logic [CW-1:0] i_fifo_data,
  output logic          o_fifo_rd,
  output logic          o_tx_stb,
  output logic [7:0]    o_tx_byte,
  input  logic          i_tx_busy
);

  localparam int NCH  = CW / 6;
  localparam int CNTW = $clog2(NCH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_NL} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     sreg_q, sreg_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              line_open_q, line_open_d;
  logic [LGIDLE-1:0] idle_cnt_q, idle_cnt_d;
  logic              tx_stb_d;
  logic [7:0]        tx_byte_d;

  logic              accept;
  logic              idle_max;
  logic              idle_load;
  logic [CW-1:0]     next_sreg;

  function automatic logic [7:0] char_map(input logic [5:0] v);
    logic [7:0] c;
    if (v < 6'd10)
      c = 8'h30 + {2'b00, v};
    else if (v < 6'd36)
      c = 8'h37 + {2'b00, v};
    else if (v < 6'd62)
      c = 8'h3D + {2'b00, v};
    else if (v == 6'd62)
      c = 8'h40;
    else
      c = 8'h25;
    return c;
  endfunction

  assign accept    = o_tx_stb && !i_tx_busy;
  assign idle_max  = &idle_cnt_q;
  assign idle_load = (state_q == S_IDLE) && !i_fifo_valid && !line_open_q && idle_max;
  assign next_sreg = sreg_q << 6;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    line_open_d = line_open_q;
    tx_stb_d    = o_tx_stb;
    tx_byte_d   = o_tx_byte;
    o_fifo_rd   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_stb_d = 1'b0;
        // Fresh data beats the newline so a refilled FIFO keeps the burst on one line.
        if (i_fifo_valid) begin
          o_fifo_rd = i_reset_n;
          sreg_d    = i_fifo_data;
          cnt_d     = CNTW'(NCH);
          state_d   = S_SHIFT;
          tx_stb_d  = 1'b1;
          tx_byte_d = char_map(i_fifo_data[CW-1 -: 6]);
        end else if (line_open_q) begin
          state_d   = S_NL;
          tx_stb_d  = 1'b1;
          tx_byte_d = 8'h0A;
        end else if (idle_max) begin
          sreg_d    = IDLE_WORD;
          cnt_d     = CNTW'(NCH);
          state_d   = S_SHIFT;
          tx_stb_d  = 1'b1;
          tx_byte_d = char_map(IDLE_WORD[CW-1 -: 6]);
        end
      end
      S_SHIFT: begin
        if (accept) begin
          sreg_d      = next_sreg;
          cnt_d       = cnt_q - CNTW'(1);
          line_open_d = 1'b1;
          if (cnt_q == CNTW'(1)) begin
            state_d  = S_IDLE;
            tx_stb_d = 1'b0;
          end else begin
            tx_byte_d = char_map(next_sreg[CW-1 -: 6]);
          end
        end
      end
      S_NL: begin
        if (accept) begin
          line_open_d = 1'b0;
          state_d     = S_IDLE;
          tx_stb_d    = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        tx_stb_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (accept || i_fifo_valid || idle_load)
      idle_cnt_d = '0;
    else if (state_q == S_IDLE && !idle_max)
      idle_cnt_d = idle_cnt_q + LGIDLE'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      line_open_q <= 1'b0;
      idle_cnt_q  <= '0;
      o_tx_stb    <= 1'b0;
      o_tx_byte   <= 8'h00;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      line_open_q <= line_open_d;
      idle_cnt_q  <= idle_cnt_d;
      o_tx_stb    <= tx_stb_d;
      o_tx_byte   <= tx_byte_d;
    end
  end

endmodule

// File: tb/tb_wbuserialize.sv
// Directed bench for wbuserialize: FIFO model in front, byte capture behind, short keep-alive timeout.
module tb_wbuserialize;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_fifo_valid;
  logic [35:0] i_fifo_data;
  logic        o_fifo_rd;
  logic        o_tx_stb;
  logic [7:0]  o_tx_byte;
  logic        i_tx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;
  int pops  = 0;
  int pop_cyc = 0;

  logic [35:0] fifo_q[$];
  logic [7:0]  rx[$];
  int          acc_cyc[$];

  logic        s_stb, s_rd;
  logic [7:0]  s_byte;
  logic        hold_prev = 1'b0;
  logic [7:0]  hold_byte = 8'h00;

  wbuserialize #(.CW(36), .LGIDLE(4), .IDLE_WORD(36'h0)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_fifo_valid (i_fifo_valid),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .o_tx_stb     (o_tx_stb),
    .o_tx_byte    (o_tx_byte),
    .i_tx_busy    (i_tx_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  function automatic string str_hex(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h", s[i])};
    return r;
  endfunction

  function automatic string rx_hex();
    string r = "";
    for (int i = 0; i < rx.size(); i++) r = {r, $sformatf("%02h", rx[i])};
    return r;
  endfunction

  task automatic drive_fifo();
    i_fifo_valid = (fifo_q.size() > 0);
    i_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 36'h0;
  endtask

  task automatic push(input logic [35:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  // One clock: sample at the falling edge, update inputs just after the rising edge.
  task automatic tick();
    logic popped;
    @(negedge i_clk);
    s_stb  = o_tx_stb;
    s_byte = o_tx_byte;
    s_rd   = o_fifo_rd;
    if (hold_prev) begin
      total++;
      if (o_tx_stb !== 1'b1 || o_tx_byte !== hold_byte) begin
        bad++;
        $display("FAIL hold_stable: got stb=%b byte=%02h, want stb=1 byte=%02h", o_tx_stb, o_tx_byte, hold_byte);
      end
    end
    hold_prev = o_tx_stb && i_tx_busy && i_reset_n;
    hold_byte = o_tx_byte;
    if (o_fifo_rd === 1'b1) begin
      total++;
      if (i_fifo_valid !== 1'b1) begin
        bad++;
        $display("FAIL rd_without_valid: got o_fifo_rd=1 with i_fifo_valid=%b, want valid=1", i_fifo_valid);
      end
    end
    if (o_tx_stb === 1'b1 && !i_tx_busy && i_reset_n) begin
      rx.push_back(o_tx_byte);
      acc_cyc.push_back(cyc);
    end
    popped = (o_fifo_rd === 1'b1) && i_reset_n;
    if (popped) begin
      pops++;
      pop_cyc = cyc;
    end
    @(posedge i_clk);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    cyc++;
    drive_fifo();
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && rx.size() < n; i++) tick();
  endtask

  task automatic do_reset();
    i_tx_busy = 1'b0;
    i_reset_n = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
    rx.delete();
    acc_cyc.delete();
    pops = 0;
    hold_prev = 1'b0;
    base = cyc;
  endtask

  task automatic test_reset();
    push(36'h000000041);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (s_stb !== 1'b0) begin
        bad++;
        $display("FAIL reset_stb[%0d]: got %b, want 0", i, s_stb);
      end
      total++;
      if (s_rd !== 1'b0) begin
        bad++;
        $display("FAIL reset_rd[%0d]: got %b, want 0", i, s_rd);
      end
    end
    total++;
    if (o_tx_byte !== 8'h00) begin
      bad++;
      $display("FAIL reset_byte: got %02h, want 00", o_tx_byte);
    end
    total++;
    if (pops !== 0) begin
      bad++;
      $display("FAIL reset_pops: got %0d, want 0", pops);
    end
    fifo_q.delete();
    drive_fifo();
  endtask

  task automatic test_single_word();
    int lat, span;
    do_reset();
    push(36'h000000041);
    run_until(7, 40);
    total++;
    if (rx_hex() != str_hex("000011\n")) begin
      bad++;
      $display("FAIL single_bytes: got %s, want %s", rx_hex(), str_hex("000011\n"));
    end
    total++;
    if (pops !== 1) begin
      bad++;
      $display("FAIL single_pops: got %0d, want 1", pops);
    end
    lat = (acc_cyc.size() > 0) ? acc_cyc[0] - pop_cyc : -1;
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL single_latency: got %0d, want 1", lat);
    end
    span = (acc_cyc.size() > 5) ? acc_cyc[5] - acc_cyc[0] : -1;
    total++;
    if (span !== 5) begin
      bad++;
      $display("FAIL single_rate: got %0d cycles for 6 chars, want 5", span);
    end
    total++;
    if (fifo_q.size() !== 0) begin
      bad++;
      $display("FAIL single_fifo_drained: got %0d words left, want 0", fifo_q.size());
    end
  endtask

  task automatic test_busy_stall();
    do_reset();
    push(36'h000000041);
    run_until(2, 20);
    i_tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (s_stb !== 1'b1 || s_byte !== 8'h30) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got stb=%b byte=%02h, want stb=1 byte=30", i, s_stb, s_byte);
      end
    end
    total++;
    if (rx.size() !== 2) begin
      bad++;
      $display("FAIL stall_no_accept: got %0d bytes, want 2", rx.size());
    end
    i_tx_busy = 1'b0;
    run_until(7, 40);
    total++;
    if (rx_hex() != str_hex("000011\n")) begin
      bad++;
      $display("FAIL stall_bytes: got %s, want %s", rx_hex(), str_hex("000011\n"));
    end
    total++;
    if (pops !== 1) begin
      bad++;
      $display("FAIL stall_pops: got %0d, want 1", pops);
    end
  endtask

  task automatic test_back_to_back();
    int gap_w, gap_nl;
    do_reset();
    push(36'hFFFFFFFFF);
    push(36'h00000000A);
    run_until(13, 60);
    repeat (5) tick();
    total++;
    if (rx_hex() != str_hex("%%%%%%00000A\n")) begin
      bad++;
      $display("FAIL b2b_bytes: got %s, want %s", rx_hex(), str_hex("%%%%%%00000A\n"));
    end
    total++;
    if (pops !== 2) begin
      bad++;
      $display("FAIL b2b_pops: got %0d, want 2", pops);
    end
    gap_w  = (acc_cyc.size() > 6)  ? acc_cyc[6] - acc_cyc[5]   : -1;
    gap_nl = (acc_cyc.size() > 12) ? acc_cyc[12] - acc_cyc[11] : -1;
    total++;
    if (gap_w !== 2) begin
      bad++;
      $display("FAIL b2b_word_gap: got %0d, want 2", gap_w);
    end
    total++;
    if (gap_nl !== 2) begin
      bad++;
      $display("FAIL b2b_nl_gap: got %0d, want 2", gap_nl);
    end
  endtask

  task automatic test_idle_keepalive();
    int first, again;
    do_reset();
    run_until(14, 80);
    total++;
    if (rx_hex() != str_hex("000000\n000000\n")) begin
      bad++;
      $display("FAIL idle_bytes: got %s, want %s", rx_hex(), str_hex("000000\n000000\n"));
    end
    total++;
    if (pops !== 0) begin
      bad++;
      $display("FAIL idle_pops: got %0d, want 0", pops);
    end
    first = (acc_cyc.size() > 0) ? acc_cyc[0] - base : -1;
    total++;
    if (first !== 16) begin
      bad++;
      $display("FAIL idle_first_delay: got %0d, want 16", first);
    end
    again = (acc_cyc.size() > 7) ? acc_cyc[7] - acc_cyc[6] : -1;
    total++;
    if (again !== 17) begin
      bad++;
      $display("FAIL idle_repeat_delay: got %0d, want 17", again);
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    push(36'h000000041);
    run_until(3, 20);
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    tick();
    total++;
    if (s_stb !== 1'b0) begin
      bad++;
      $display("FAIL midrst_stb: got %b, want 0", s_stb);
    end
    total++;
    if (rx.size() !== 3) begin
      bad++;
      $display("FAIL midrst_count: got %0d bytes, want 3", rx.size());
    end
    total++;
    if (pops !== 1) begin
      bad++;
      $display("FAIL midrst_pops: got %0d, want 1", pops);
    end
    push(36'h000000FFF);
    run_until(10, 40);
    total++;
    if (rx_hex() != str_hex("0000000%%\n")) begin
      bad++;
      $display("FAIL midrst_bytes: got %s, want %s", rx_hex(), str_hex("0000000%%\n"));
    end
    total++;
    if (pops !== 2) begin
      bad++;
      $display("FAIL midrst_next_pops: got %0d, want 2", pops);
    end
  endtask

  initial begin
    i_reset_n    = 1'b0;
    i_tx_busy    = 1'b0;
    i_fifo_valid = 1'b0;
    i_fifo_data  = 36'h0;
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    test_single_word();
    test_busy_stall();
    test_back_to_back();
    test_idle_keepalive();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
